// File: rtl/rvm_socket_ctrl.sv
// Core socket controller: boot/hold/run sequencing of a core's reset and fetch enable,
// plus synchronised, maskable, prioritised interrupt presentation with per-line edge/level modes.
module rvm_socket_ctrl #(
  parameter int ADDR_WIDTH  = 32,
  parameter int NUM_IRQ     = 3,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  localparam int IDW        = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic                  clock_i,
  input  logic                  reset_ni,
  input  logic [ADDR_WIDTH-1:0] bootaddr_i,
  input  logic                  boot_req_i,
  input  logic                  halt_req_i,
  input  logic [NUM_IRQ-1:0]    irq_i,
  input  logic [NUM_IRQ-1:0]    irq_edge_i,
  input  logic [NUM_IRQ-1:0]    irq_mask_i,
  input  logic                  irq_ack_i,
  output logic                  core_rst_no,
  output logic [ADDR_WIDTH-1:0] core_bootaddr_o,
  output logic                  core_fetch_en_o,
  output logic                  core_irq_o,
  output logic [IDW-1:0]        core_irq_id_o,
  output logic                  running_o
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2
  } state_e;

  state_e                        state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]         bootaddr_q;
  logic                          boot_take;
  logic                          enter_idle;
  logic                          run_q;

  logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] irq_sync_q;
  logic [NUM_IRQ-1:0]            irq_prev_q;
  logic [NUM_IRQ-1:0]            irq_lvl;
  logic [NUM_IRQ-1:0]            irq_rise;
  logic [NUM_IRQ-1:0]            pending_q, pending_d, pending_edge;
  logic [NUM_IRQ-1:0]            active;
  logic [NUM_IRQ-1:0]            ack_clr;
  logic [IDW-1:0]                irq_id;

  // Sequencer: halt has priority over boot in every state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    boot_take = 1'b0;
    case (state_q)
      IDLE: begin
        if (boot_req_i && !halt_req_i) begin
          boot_take = 1'b1;
          state_d   = HOLD;
          cnt_d     = CNT_W'(HOLD_CYCLES);
        end
      end
      HOLD: begin
        if (halt_req_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RUN: begin
        if (halt_req_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign enter_idle = (state_q != IDLE) && (state_d == IDLE);

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bootaddr_q <= '0;
      run_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      run_q   <= (state_d == RUN);
      if (boot_take) begin
        bootaddr_q <= bootaddr_i;
      end
    end
  end

  // Interrupt front end: synchroniser chain, then one extra flop for edge detection.
  assign irq_lvl  = irq_sync_q[SYNC_STAGES-1];
  assign irq_rise = irq_lvl & ~irq_prev_q;
  assign active   = pending_q & irq_mask_i;

  always_comb begin
    irq_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (active[i]) begin
        irq_id = IDW'(i);
      end
    end
  end

  always_comb begin
    ack_clr = '0;
    if (irq_ack_i && core_irq_o) begin
      ack_clr[irq_id] = 1'b1;
    end
  end

  // A rise arriving with its own ack re-arms the line; leaving RUN/HOLD drops stale edges.
  assign pending_edge = enter_idle ? '0 : ((pending_q & ~ack_clr) | irq_rise);
  assign pending_d    = (irq_edge_i & pending_edge) | (~irq_edge_i & irq_lvl);

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      irq_sync_q <= '0;
      irq_prev_q <= '0;
      pending_q  <= '0;
    end else begin
      irq_sync_q <= {irq_sync_q[SYNC_STAGES-2:0], irq_i};
      irq_prev_q <= irq_lvl;
      pending_q  <= pending_d;
    end
  end

  assign core_rst_no     = run_q;
  assign core_fetch_en_o = run_q;
  assign running_o       = run_q;
  assign core_bootaddr_o = bootaddr_q;
  assign core_irq_o      = (state_q == RUN) && (|active);
  assign core_irq_id_o   = irq_id;

endmodule
